// File: rtl/custom_axi_accel.sv
// Streaming accelerator: DEPTH-entry input FIFO feeding a pass/add/accumulate engine with valid/ready output.
// Define CUSTOM_AXI_ACCEL_SAT_EN to saturate modes 1 and 2 (and flag err_o) instead of wrapping.
module custom_axi_accel #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4,
  parameter int LATENCY    = 2,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [DATA_WIDTH-1:0]    in_data_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [1:0]               mode_i,
  input  logic [DATA_WIDTH-1:0]    addend_i,
  input  logic                     acc_clr_i,
  output logic [DATA_WIDTH-1:0]    out_data_o,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [1:0]               status_o,
  output logic                     err_o,
  input  logic                     err_clr_i,
  output logic [$clog2(DEPTH):0]   fifo_count_o,
  output logic [CNT_WIDTH-1:0]     done_cnt_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int LAT_W = $clog2(LATENCY) + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERROR = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic                    in_ready_q, in_ready_d;
  logic [DATA_WIDTH-1:0]   word_q, word_d, addend_q, addend_d;
  logic [1:0]              mode_q, mode_d;
  logic [LAT_W-1:0]        lat_cnt_q, lat_cnt_d;
  logic [DATA_WIDTH-1:0]   acc_q, acc_d, out_data_q, out_data_d;
  logic                    err_q, err_d;
  logic [CNT_WIDTH-1:0]    done_cnt_q, done_cnt_d;

  logic                    push, pop, last_busy, sat;
  logic [DATA_WIDTH-1:0]   op_a, op_b, result;

  assign push      = in_valid_i && in_ready_q;
  assign pop       = (state_q == ST_IDLE) && (count_q != '0);
  assign last_busy = (state_q == ST_BUSY) && (lat_cnt_q == LAT_W'(LATENCY - 1));

  // NOTE: every signal assigned in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (pop) state_d = (mode_i == 2'd3) ? ST_ERROR : ST_BUSY;
      ST_BUSY:  if (last_busy) state_d = ST_DONE;
      ST_DONE:  if (out_ready_i) state_d = ST_IDLE;
      ST_ERROR: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FIFO bookkeeping; ready is registered so a same-cycle pop never admits a push into a full FIFO.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    in_ready_d = (count_d < CNT_W'(DEPTH));
  end

  always_comb begin
    word_d   = word_q;
    mode_d   = mode_q;
    addend_d = addend_q;
    if (pop) begin
      word_d   = mem_q[rd_ptr_q];
      mode_d   = mode_i;
      addend_d = addend_i;
    end
    lat_cnt_d = (state_q == ST_BUSY && !last_busy) ? lat_cnt_q + LAT_W'(1) : '0;

    op_a = word_q;
    case (mode_q)
      2'd1:    op_b = addend_q;
      2'd2:    op_b = acc_clr_i ? '0 : acc_q;
      default: op_b = '0;
    endcase
`ifdef CUSTOM_AXI_ACCEL_SAT_EN
    begin
      logic [DATA_WIDTH:0] sum_wide;
      sum_wide = {1'b0, op_a} + {1'b0, op_b};
      sat      = sum_wide[DATA_WIDTH];
      result   = sat ? '1 : sum_wide[DATA_WIDTH-1:0];
    end
`else
    sat    = 1'b0;
    result = op_a + op_b;
`endif

    acc_d      = acc_clr_i ? '0 : acc_q;
    out_data_d = out_data_q;
    if (last_busy) begin
      out_data_d = result;
      if (mode_q == 2'd2) acc_d = result;
    end

    // A new error outranks a simultaneous clear.
    if ((state_q == ST_ERROR) || (last_busy && sat)) err_d = 1'b1;
    else if (err_clr_i)                              err_d = 1'b0;
    else                                             err_d = err_q;

    done_cnt_d = (state_q == ST_DONE && out_ready_i) ? done_cnt_q + CNT_WIDTH'(1) : done_cnt_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b0;
      word_q     <= '0;
      mode_q     <= '0;
      addend_q   <= '0;
      lat_cnt_q  <= '0;
      acc_q      <= '0;
      out_data_q <= '0;
      err_q      <= 1'b0;
      done_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
      word_q     <= word_d;
      mode_q     <= mode_d;
      addend_q   <= addend_d;
      lat_cnt_q  <= lat_cnt_d;
      acc_q      <= acc_d;
      out_data_q <= out_data_d;
      err_q      <= err_d;
      done_cnt_q <= done_cnt_d;
    end
  end

  // NOTE: storage array is not reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= in_data_i;
  end

  always_comb begin
    in_ready_o   = in_ready_q;
    out_data_o   = out_data_q;
    out_valid_o  = (state_q == ST_DONE);
    status_o     = state_q;
    err_o        = err_q;
    fifo_count_o = count_q;
    done_cnt_o   = done_cnt_q;
  end

endmodule

// File: tb/tb_custom_axi_accel.sv
// Directed self-checking bench for custom_axi_accel (default parameters, LATENCY=2, DEPTH=4).
module tb_custom_axi_accel;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [15:0] in_data_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [1:0]  mode_i;
  logic [15:0] addend_i;
  logic        acc_clr_i;
  logic [15:0] out_data_o;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [1:0]  status_o;
  logic        err_o;
  logic        err_clr_i;
  logic [2:0]  fifo_count_o;
  logic [7:0]  done_cnt_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_i = ~clk_i;

  custom_axi_accel dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .in_data_i    (in_data_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .mode_i       (mode_i),
    .addend_i     (addend_i),
    .acc_clr_i    (acc_clr_i),
    .out_data_o   (out_data_o),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .status_o     (status_o),
    .err_o        (err_o),
    .err_clr_i    (err_clr_i),
    .fifo_count_o (fifo_count_o),
    .done_cnt_o   (done_cnt_o)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_word(input logic [15:0] d);
    @(negedge clk_i);
    in_data_i  = d;
    in_valid_i = 1'b1;
    @(negedge clk_i);
    in_valid_i = 1'b0;
  endtask

  task automatic expect_out(input logic [15:0] exp, input string name);
    int waited = 0;
    while (!out_valid_o && waited < 40) begin
      @(negedge clk_i);
      waited++;
    end
    n_cmp++;
    if (out_valid_o !== 1'b1) begin
      n_bad++;
      $display("FAIL %s: out_valid_o never rose (timeout), required 0x%04h", name, exp);
    end else if (out_data_o !== exp) begin
      n_bad++;
      $display("FAIL %s: out_data_o=0x%04h required 0x%04h", name, out_data_o, exp);
    end
    @(negedge clk_i);
  endtask

  task automatic pulse_acc_clr();
    @(negedge clk_i);
    acc_clr_i = 1'b1;
    @(negedge clk_i);
    acc_clr_i = 1'b0;
  endtask

  task automatic pulse_err_clr();
    @(negedge clk_i);
    err_clr_i = 1'b1;
    @(negedge clk_i);
    err_clr_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; in_data_i = '0; in_valid_i = 1'b0; mode_i = 2'd0; addend_i = '0;
    acc_clr_i = 1'b0; out_ready_i = 1'b1; err_clr_i = 1'b0;
    repeat (3) @(negedge clk_i);
    n_cmp++;
    if ({in_ready_o, out_valid_o, out_data_o, status_o, err_o, fifo_count_o, done_cnt_o} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: rdy=%b vld=%b data=0x%04h st=%0d err=%b cnt=%0d done=%0d required all 0",
               in_ready_o, out_valid_o, out_data_o, status_o, err_o, fifo_count_o, done_cnt_o);
    end
    rst_i = 1'b0;
    @(negedge clk_i);
    n_cmp++;
    if (in_ready_o !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_release_ready: in_ready_o=%b required 1", in_ready_o);
    end
  endtask

  task automatic test_pass();
    int exp_st[5] = '{0, 1, 1, 2, 0};
    mode_i = 2'd0;
    push_word(16'h1234);
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if (status_o !== 2'(exp_st[k]) || out_valid_o !== (k == 3)) begin
        n_bad++;
        $display("FAIL pass_seq[%0d]: status=%0d valid=%b required status=%0d valid=%b",
                 k, status_o, out_valid_o, exp_st[k], (k == 3));
      end
      if (k == 3) begin
        n_cmp++;
        if (out_data_o !== 16'h1234) begin
          n_bad++;
          $display("FAIL pass_data: out_data_o=0x%04h required 0x1234", out_data_o);
        end
      end
      if (k < 4) @(negedge clk_i);
    end
    n_cmp++;
    if (done_cnt_o !== 8'd1) begin
      n_bad++;
      $display("FAIL pass_done_cnt: done_cnt_o=%0d required 1", done_cnt_o);
    end
  endtask

  task automatic test_add();
    mode_i   = 2'd1;
    addend_i = 16'h0010;
    push_word(16'h00F0);
    expect_out(16'h0100, "add_basic");
    n_cmp++;
    if (err_o !== 1'b0) begin
      n_bad++;
      $display("FAIL add_no_err: err_o=%b required 0", err_o);
    end
    push_word(16'hFFF8);
`ifdef CUSTOM_AXI_ACCEL_SAT_EN
    expect_out(16'hFFFF, "add_saturate");
    n_cmp++;
    if (err_o !== 1'b1) begin
      n_bad++;
      $display("FAIL add_sat_err: err_o=%b required 1", err_o);
    end
`else
    expect_out(16'h0008, "add_wrap");
    n_cmp++;
    if (err_o !== 1'b0) begin
      n_bad++;
      $display("FAIL add_wrap_err: err_o=%b required 0", err_o);
    end
`endif
    n_cmp++;
    if (done_cnt_o !== 8'd3) begin
      n_bad++;
      $display("FAIL add_done_cnt: done_cnt_o=%0d required 3", done_cnt_o);
    end
    pulse_err_clr();
  endtask

  task automatic test_accumulate();
    mode_i = 2'd2;
    pulse_acc_clr();
    push_word(16'd3);
    expect_out(16'd3, "acc_3");
    push_word(16'd4);
    expect_out(16'd7, "acc_7");
    push_word(16'd5);
    expect_out(16'd12, "acc_12");
    pulse_acc_clr();
    push_word(16'd9);
    expect_out(16'd9, "acc_after_clr");
    n_cmp++;
    if (done_cnt_o !== 8'd7) begin
      n_bad++;
      $display("FAIL acc_done_cnt: done_cnt_o=%0d required 7", done_cnt_o);
    end
  endtask

  task automatic test_backpressure();
    mode_i      = 2'd0;
    out_ready_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      in_data_i  = 16'h00A0 + 16'(i);
      in_valid_i = 1'b1;
    end
    @(negedge clk_i);
    in_valid_i = 1'b0;
    n_cmp++;
    if (fifo_count_o !== 3'd4 || in_ready_o !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_full: fifo_count=%0d in_ready=%b required 4 and 0", fifo_count_o, in_ready_o);
    end
    n_cmp++;
    if (out_valid_o !== 1'b1 || out_data_o !== 16'h00A0) begin
      n_bad++;
      $display("FAIL bp_held: valid=%b data=0x%04h required 1 and 0x00a0", out_valid_o, out_data_o);
    end
    repeat (3) @(negedge clk_i);
    n_cmp++;
    if (out_data_o !== 16'h00A0) begin
      n_bad++;
      $display("FAIL bp_stable: out_data_o=0x%04h required 0x00a0", out_data_o);
    end
    out_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) expect_out(16'h00A0 + 16'(i), "bp_drain");
    begin
      bit extra = 1'b0;
      repeat (12) begin
        @(negedge clk_i);
        if (out_valid_o) extra = 1'b1;
      end
      n_cmp++;
      if (extra || fifo_count_o !== 3'd0) begin
        n_bad++;
        $display("FAIL bp_no_extra: extra_valid=%b fifo_count=%0d required 0 and 0", extra, fifo_count_o);
      end
    end
    n_cmp++;
    if (done_cnt_o !== 8'd12) begin
      n_bad++;
      $display("FAIL bp_done_cnt: done_cnt_o=%0d required 12", done_cnt_o);
    end
  endtask

  task automatic test_error();
    int  err_cycles = 0;
    bit  saw_valid  = 1'b0;
    mode_i = 2'd3;
    push_word(16'h5555);
    for (int k = 0; k < 8; k++) begin
      if (status_o == 2'd3) err_cycles++;
      if (out_valid_o) saw_valid = 1'b1;
      @(negedge clk_i);
    end
    n_cmp++;
    if (err_cycles != 1 || saw_valid) begin
      n_bad++;
      $display("FAIL err_path: error_cycles=%0d saw_valid=%b required 1 and 0", err_cycles, saw_valid);
    end
    n_cmp++;
    if (err_o !== 1'b1 || done_cnt_o !== 8'd12 || status_o !== 2'd0) begin
      n_bad++;
      $display("FAIL err_state: err=%b done=%0d status=%0d required 1, 12, 0", err_o, done_cnt_o, status_o);
    end
    pulse_err_clr();
    n_cmp++;
    if (err_o !== 1'b0) begin
      n_bad++;
      $display("FAIL err_clear: err_o=%b required 0", err_o);
    end
    // Clear held high across a fresh error: set must win for one cycle, then the clear takes effect.
    err_clr_i = 1'b1;
    push_word(16'h6666);
    begin
      int waited = 0;
      while (status_o !== 2'd3 && waited < 20) begin
        @(negedge clk_i);
        waited++;
      end
    end
    @(negedge clk_i);
    n_cmp++;
    if (err_o !== 1'b1) begin
      n_bad++;
      $display("FAIL err_set_wins: err_o=%b required 1", err_o);
    end
    @(negedge clk_i);
    n_cmp++;
    if (err_o !== 1'b0) begin
      n_bad++;
      $display("FAIL err_clr_after: err_o=%b required 0", err_o);
    end
    err_clr_i = 1'b0;
    mode_i    = 2'd0;
  endtask

  task automatic test_reset_mid();
    mode_i = 2'd0;
    @(negedge clk_i);
    in_data_i = 16'h7777; in_valid_i = 1'b1;
    @(negedge clk_i);
    in_data_i = 16'h8888;
    @(negedge clk_i);
    in_valid_i = 1'b0;
    n_cmp++;
    if (status_o !== 2'd1 || fifo_count_o !== 3'd1) begin
      n_bad++;
      $display("FAIL rst_mid_setup: status=%0d fifo_count=%0d required 1 and 1", status_o, fifo_count_o);
    end
    #2 rst_i = 1'b1;
    #1;
    n_cmp++;
    if ({in_ready_o, out_valid_o, out_data_o, status_o, err_o, fifo_count_o, done_cnt_o} !== '0) begin
      n_bad++;
      $display("FAIL rst_mid_async: rdy=%b vld=%b data=0x%04h st=%0d err=%b cnt=%0d done=%0d required all 0",
               in_ready_o, out_valid_o, out_data_o, status_o, err_o, fifo_count_o, done_cnt_o);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    begin
      bit stale = 1'b0;
      repeat (12) begin
        @(negedge clk_i);
        if (out_valid_o) stale = 1'b1;
      end
      n_cmp++;
      if (stale || fifo_count_o !== 3'd0 || status_o !== 2'd0) begin
        n_bad++;
        $display("FAIL rst_mid_stale: stale=%b fifo_count=%0d status=%0d required 0, 0, 0",
                 stale, fifo_count_o, status_o);
      end
    end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_add();
    test_accumulate();
    test_backpressure();
    test_error();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
